// File: rtl/pathtracer_frame_ctrl.sv
// Frame sequencer for the Pathtracer core: streams the config bank into the core,
// then forwards exactly one frame of pixel bytes through a 2-entry output buffer.
module pathtracer_frame_ctrl #(
   parameter int unsigned CFG_WORDS   = 8,
   parameter int unsigned FRAME_BYTES = 3072,
   localparam int unsigned AW = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1,
   localparam int unsigned CW = $clog2(FRAME_BYTES + 1)
) (
   input  logic          clk,
   input  logic          arst_n,
   input  logic          cfg_wr_en,
   input  logic [AW-1:0] cfg_wr_addr,
   input  logic [11:0]   cfg_wr_data,
   input  logic          start,
   input  logic          abort,
   output logic [11:0]   pt_in_dat,
   output logic          pt_in_vld,
   input  logic          pt_in_rdy,
   input  logic [7:0]    pt_pxl_dat,
   input  logic          pt_pxl_vld,
   output logic          pt_pxl_rdy,
   output logic [7:0]    pxl_out_dat,
   output logic          pxl_out_vld,
   output logic          pxl_out_last,
   input  logic          pxl_out_rdy,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] byte_count
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StLoad   = 3'd1;
   localparam logic [2:0] StRender = 3'd2;
   localparam logic [2:0] StFlush  = 3'd3;
   localparam logic [2:0] StDone   = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [11:0]   cfg_q [CFG_WORDS];
   logic [7:0]    fifo_dat_q [2];
   logic [1:0]    fifo_last_q;
   logic          wr_ptr_q, rd_ptr_q;
   logic [1:0]    fifo_cnt_q, fifo_cnt_d;
   logic          buf_full, in_hs, pxl_push, pxl_pop, fifo_clr, frame_end, cfg_we;

   assign buf_full     = (fifo_cnt_q == 2'd2);
   assign pt_in_vld    = (state_q == StLoad);
   assign pt_in_dat    = pt_in_vld ? cfg_q[idx_q] : 12'h000;
   // Decoded from registered state only; no path from pxl_out_rdy.
   assign pt_pxl_rdy   = (state_q == StRender) & ~buf_full & (cnt_q < CW'(FRAME_BYTES));
   assign pxl_out_vld  = (fifo_cnt_q != 2'd0);
   assign pxl_out_dat  = pxl_out_vld ? fifo_dat_q[rd_ptr_q] : 8'h00;
   assign pxl_out_last = pxl_out_vld & fifo_last_q[rd_ptr_q];
   assign busy         = (state_q != StIdle);
   assign done         = (state_q == StDone);
   assign byte_count   = cnt_q;

   // Abort outranks every handshake in the same cycle.
   assign in_hs     = pt_in_vld & pt_in_rdy & ~abort;
   assign pxl_push  = pt_pxl_vld & pt_pxl_rdy & ~abort;
   assign pxl_pop   = pxl_out_vld & pxl_out_rdy & ~abort;
   assign fifo_clr  = (abort & busy) | ((state_q == StIdle) & start);
   assign frame_end = (cnt_q == CW'(FRAME_BYTES - 1));
   assign cfg_we    = (state_q == StIdle) & cfg_wr_en & (32'(cfg_wr_addr) < CFG_WORDS);

   always_comb begin
      fifo_cnt_d = fifo_cnt_q;
      if (fifo_clr) begin
         fifo_cnt_d = 2'd0;
      end else if (pxl_push & ~pxl_pop) begin
         fifo_cnt_d = fifo_cnt_q + 2'd1;
      end else if (pxl_pop & ~pxl_push) begin
         fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               idx_d   = '0;
               cnt_d   = '0;
            end
         end
         StLoad: begin
            if (in_hs) begin
               if (idx_q == AW'(CFG_WORDS - 1)) state_d = StRender;
               else                             idx_d   = idx_q + AW'(1);
            end
         end
         StRender: begin
            if (pxl_push) begin
               cnt_d = cnt_q + CW'(1);
               if (frame_end) state_d = StFlush;
            end
         end
         // Leave as the last byte pops so done lands in the following cycle.
         StFlush: if (fifo_cnt_d == 2'd0) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (abort && state_q != StIdle) state_d = StIdle;
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         cnt_q       <= '0;
         cfg_q       <= '{default: 12'h000};
         fifo_dat_q  <= '{default: 8'h00};
         fifo_last_q <= 2'b00;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         fifo_cnt_q  <= 2'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         fifo_cnt_q <= fifo_cnt_d;
         if (cfg_we) cfg_q[cfg_wr_addr] <= cfg_wr_data;
         if (fifo_clr) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
         end else begin
            if (pxl_push) begin
               fifo_dat_q[wr_ptr_q]  <= pt_pxl_dat;
               fifo_last_q[wr_ptr_q] <= frame_end;
               wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pxl_pop) rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

endmodule

// File: doc/pathtracer_frame_ctrl.md
# pathtracer_frame_ctrl

Frame-level sequencer between the pad/host side and the `Pathtracer` core. It holds a small bank of 12-bit scene-configuration words and streams them into the core's `inputChannel` vld/rdy port when a frame is started. It then accepts exactly one frame of 8-bit serial pixel bytes from the core's `output_pxl_serial` port and forwards them through a 2-entry buffer, tagging the final byte. It reports busy/done status to the host.

## Interface
- `CFG_WORDS`, default 8: number of configuration words sent per frame; legal range 1..64.
- `FRAME_BYTES`, default 3072: pixel bytes per frame (32×32×3); must be ≥1.
- `AW` (derived): `$clog2(CFG_WORDS)`, minimum 1.
- `CW` (derived): `$clog2(FRAME_BYTES+1)`.
- `clk`  in  1  single clock for the whole block.
- `arst_n`  in  1  reset, asynchronous, active-low.
- `cfg_wr_en`  in  1  write strobe for the config bank.
- `cfg_wr_addr`  in  AW  config word index.
- `cfg_wr_data`  in  12  config word value.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `abort`  in  1  cancel the current frame.
- `pt_in_dat`  out  12  config word to `Pathtracer.inputChannel_rsc_dat`.
- `pt_in_vld`  out  1  valid to the core.
- `pt_in_rdy`  in  1  ready from the core.
- `pt_pxl_dat`  in  8  pixel byte from `Pathtracer.output_pxl_serial_rsc_dat`.
- `pt_pxl_vld`  in  1  valid from the core.
- `pt_pxl_rdy`  out  1  ready to the core.
- `pxl_out_dat`  out  8  buffered pixel byte.
- `pxl_out_vld`  out  1  valid for the buffered byte.
- `pxl_out_last`  out  1  high with the final byte of the frame.
- `pxl_out_rdy`  in  1  downstream ready.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  single-cycle pulse at frame completion.
- `byte_count`  out  CW  bytes accepted from the core in the current/last frame.

## Operation
- FSM states: IDLE, LOAD, RENDER, FLUSH, DONE.
- **IDLE**
  - `start`=1 → LOAD. The word index and `byte_count` clear to 0 and the buffer is emptied.
  - `cfg_wr_en` writes `cfg[cfg_wr_addr]`. Out-of-range addresses are ignored. Config writes are accepted only in IDLE and ignored in every other state.
- **LOAD**
  - `pt_in_vld`=1, `pt_in_dat`=`cfg[idx]`.
  - On `pt_in_vld & pt_in_rdy`: idx++. If the accepted word was idx=`CFG_WORDS`-1, go to RENDER.
  - `pt_in_dat` is stable while stalled.
- **RENDER**
  - `pt_pxl_rdy` = `!buf_full & (byte_count < FRAME_BYTES)`. It is registered-state-only, with no combinational path from `pxl_out_rdy`.
  - Each accepted byte is pushed into the 2-entry FIFO with `last` = (`byte_count`==`FRAME_BYTES`-1), and `byte_count` increments.
  - After the final byte is accepted, go to FLUSH.
- **FLUSH**: wait until the FIFO is empty (the last byte has been popped), then go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then IDLE. `byte_count` holds its value until the next `start`.
- **Output FIFO**
  - `pxl_out_*` are driven from the head entry.
  - A pop occurs on `pxl_out_vld & pxl_out_rdy`.
  - Push and pop in the same cycle are allowed when the FIFO is not full. The count is unchanged.
- **abort**
  - Abort in any non-IDLE state → IDLE next edge.
  - The FIFO is flushed, `pt_in_vld`, `pt_pxl_rdy` and `pxl_out_vld` drop to 0, and no `done` pulse is generated.
  - Abort has priority over every handshake in the same cycle: that handshake is not counted.
  - Abort in IDLE has no effect. If `start` and `abort` are both high in IDLE, `start` wins.
- `start` in any non-IDLE state is ignored.
- Arithmetic: `byte_count` never exceeds `FRAME_BYTES` and does not wrap. Surplus core bytes are never accepted because `pt_pxl_rdy` stays 0.

## Timing
- Reset (`arst_n`=0, asynchronous):
  - State is IDLE; all `cfg` words are 0.
  - `pt_in_vld`, `pt_pxl_rdy`, `pxl_out_vld`, `pxl_out_last`, `busy`, `done` are 0.
  - `pt_in_dat`, `pxl_out_dat`, `byte_count` are 0.
- Reset mid-frame behaves like abort, and the config bank is also cleared.
- `start` sampled at edge k → `busy`=1 and `pt_in_vld`=1 with `cfg[0]` from cycle k+1.
- With `pt_in_rdy` held at 1: one word per cycle, and RENDER is entered CFG_WORDS cycles after LOAD entry.
- Pixel latency: a byte accepted at edge t is visible on `pxl_out_dat`/`pxl_out_vld` in cycle t+1.
- Full throughput (1 byte/cycle) is sustained when `pxl_out_rdy`=1.
- `done` is asserted in the cycle after the edge that pops the last byte. `busy` falls together with `done`.
- All outputs are registered or decoded from registered state only.

## Test plan
- **Config load, no stall:** write cfg[i]=0x100+i for i=0..7, pulse `start`, `pt_in_rdy`=1 → `pt_in_dat` sequence 0x100..0x107 on 8 consecutive cycles starting 1 cycle after `start`, then `pt_pxl_rdy` rises.
- **Backpressure on load:** `pt_in_rdy` toggles 1/0 → each word is held stable while `rdy`=0, no word is skipped or repeated, and exactly 8 handshakes occur.
- **Frame stream** (`FRAME_BYTES`=12): core sends bytes 0x00..0x0B, then more with `vld` still high, and `pxl_out_rdy` is random.
  - Output is 0x00..0x0B in order, and `pxl_out_last` is set only on 0x0B.
  - `byte_count`=12, and `pt_pxl_rdy` stays 0 after the 12th byte.
  - `done` is a single 1-cycle pulse.
- **Downstream stall:** `pxl_out_rdy`=0 during RENDER → after 2 accepted bytes `pt_pxl_rdy`=0. Release → streaming resumes with no loss or duplication.
- **Abort:** assert `abort` at config word 3, and again at byte 5 of RENDER → next cycle state is IDLE, all vld/rdy are 0, `busy`=0, and no `done` pulse. A following `start` replays from cfg[0].
- **Ignored inputs:** `start` and `cfg_wr_en` during RENDER → no restart and config unchanged. Async reset mid-RENDER → all outputs 0 immediately and config reads back as 0.
